// File: rtl/exe_pkg.sv
// Shared definitions for the MIPS execute stage: ALU command codes,
// muldiv FSM state encoding and the muldiv command predicate.
package exe_pkg;

   localparam logic [3:0] EXE_ADD = 4'b0000;
   localparam logic [3:0] EXE_SUB = 4'b0010;
   localparam logic [3:0] EXE_AND = 4'b0100;
   localparam logic [3:0] EXE_OR  = 4'b0101;
   localparam logic [3:0] EXE_NOR = 4'b0110;
   localparam logic [3:0] EXE_XOR = 4'b0111;
   localparam logic [3:0] EXE_SLL = 4'b1000;
   localparam logic [3:0] EXE_SRA = 4'b1001;
   localparam logic [3:0] EXE_SRL = 4'b1010;
   localparam logic [3:0] EXE_MUL = 4'b1100;
   localparam logic [3:0] EXE_DIV = 4'b1101;
   localparam logic [3:0] EXE_REM = 4'b1110;

   localparam logic [1:0] MD_IDLE = 2'd0;
   localparam logic [1:0] MD_BUSY = 2'd1;
   localparam logic [1:0] MD_DONE = 2'd2;

   function automatic logic is_muldiv(input logic [3:0] cmd);
      return (cmd == EXE_MUL) || (cmd == EXE_DIV) || (cmd == EXE_REM);
   endfunction

endpackage

// File: rtl/exe_stage_if.sv
// ID/EXE -> EXE -> EXE/MEM signal bundle for the execute stage.
// master drives the ID/EXE side, slave is the execute stage itself.
interface exe_stage_if #(
   parameter int DATA_W = 32,
   parameter int REG_AW = 5
);
   logic [DATA_W-1:0] PC;
   logic [DATA_W-1:0] Val1;
   logic [DATA_W-1:0] Val2;
   logic [DATA_W-1:0] Reg2;
   logic [REG_AW-1:0] Dest;
   logic              Br_taken;
   logic [3:0]        EXE_cmd;
   logic              MEM_R_en;
   logic              MEM_W_en;
   logic              WB_en;

   logic [DATA_W-1:0] ALU_result;
   logic [DATA_W-1:0] Br_addr;
   logic              Br_taken_out;
   logic [DATA_W-1:0] ST_val;
   logic [REG_AW-1:0] Dest_out;
   logic              MEM_R_en_out;
   logic              MEM_W_en_out;
   logic              WB_en_out;
   logic              muldiv_stall;

   modport master (
      output PC, Val1, Val2, Reg2, Dest, Br_taken, EXE_cmd,
      output MEM_R_en, MEM_W_en, WB_en,
      input  ALU_result, Br_addr, Br_taken_out, ST_val, Dest_out,
      input  MEM_R_en_out, MEM_W_en_out, WB_en_out, muldiv_stall
   );

   modport slave (
      input  PC, Val1, Val2, Reg2, Dest, Br_taken, EXE_cmd,
      input  MEM_R_en, MEM_W_en, WB_en,
      output ALU_result, Br_addr, Br_taken_out, ST_val, Dest_out,
      output MEM_R_en_out, MEM_W_en_out, WB_en_out, muldiv_stall
   );
endinterface

// File: rtl/exe_stage_muldiv_unit.sv
// Iterative radix-2 multiply / restoring divide, one bit per cycle.
// MULDIV_SIGNED_EN selects two's-complement operands (default unsigned).
module muldiv_unit
   import exe_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start_i,
   input  logic [3:0]        op_i,
   input  logic [DATA_W-1:0] a_i,
   input  logic [DATA_W-1:0] b_i,
   output logic              busy_o,
   output logic              done_o,
   output logic [DATA_W-1:0] result_o
);

   localparam int CW = $clog2(DATA_W);

   logic [1:0]        st_q, st_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [3:0]        op_q, op_d;
   logic [DATA_W-1:0] a_q, a_d;
   logic [DATA_W-1:0] b_q, b_d;
   logic [DATA_W:0]   acc_q, acc_d;
   logic              neg_q, neg_d;
   logic [DATA_W-1:0] res_q, res_d;

   logic [DATA_W-1:0] mag_a, mag_b;
   logic              neg_cap;
   logic [DATA_W-1:0] mul_acc;
   logic [DATA_W:0]   div_sh, div_rem;
   logic              div_ge;
   logic [DATA_W-1:0] raw, fin;

`ifdef MULDIV_SIGNED_EN
   logic sa, sb;
   always_comb begin
      sa    = a_i[DATA_W-1];
      sb    = b_i[DATA_W-1];
      mag_a = sa ? -a_i : a_i;
      mag_b = sb ? -b_i : b_i;
      // quotient of x/0 stays all ones, so never negate it
      if (op_i == EXE_MUL)      neg_cap = sa ^ sb;
      else if (op_i == EXE_DIV) neg_cap = (sa ^ sb) && (b_i != '0);
      else                      neg_cap = sa;
   end
`else
   always_comb begin
      mag_a   = a_i;
      mag_b   = b_i;
      neg_cap = 1'b0;
   end
`endif

   always_comb begin
      mul_acc = acc_q[DATA_W-1:0] + (b_q[0] ? a_q : '0);
      div_sh  = {acc_q[DATA_W-1:0], a_q[DATA_W-1]};
      div_ge  = div_sh >= {1'b0, b_q};
      div_rem = div_ge ? div_sh - {1'b0, b_q} : div_sh;
      if (op_q == EXE_MUL)      raw = mul_acc;
      else if (op_q == EXE_DIV) raw = {a_q[DATA_W-2:0], div_ge};
      else                      raw = div_rem[DATA_W-1:0];
      fin = neg_q ? -raw : raw;
   end

   always_comb begin
      st_d  = st_q;
      cnt_d = cnt_q;
      op_d  = op_q;
      a_d   = a_q;
      b_d   = b_q;
      acc_d = acc_q;
      neg_d = neg_q;
      res_d = res_q;
      case (st_q)
         MD_IDLE: begin
            if (start_i) begin
               st_d  = MD_BUSY;
               cnt_d = CW'(DATA_W - 1);
               op_d  = op_i;
               a_d   = mag_a;
               b_d   = mag_b;
               acc_d = '0;
               neg_d = neg_cap;
            end
         end
         MD_BUSY: begin
            if (op_q == EXE_MUL) begin
               acc_d = {1'b0, mul_acc};
               a_d   = a_q << 1;
               b_d   = b_q >> 1;
            end else begin
               acc_d = div_rem;
               a_d   = {a_q[DATA_W-2:0], div_ge};
            end
            if (cnt_q == '0) begin
               st_d  = MD_DONE;
               res_d = fin;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         MD_DONE: st_d = MD_IDLE;
         default: st_d = MD_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         st_q  <= MD_IDLE;
         cnt_q <= '0;
         op_q  <= '0;
         a_q   <= '0;
         b_q   <= '0;
         acc_q <= '0;
         neg_q <= 1'b0;
         res_q <= '0;
      end else begin
         st_q  <= st_d;
         cnt_q <= cnt_d;
         op_q  <= op_d;
         a_q   <= a_d;
         b_q   <= b_d;
         acc_q <= acc_d;
         neg_q <= neg_d;
         res_q <= res_d;
      end
   end

   assign busy_o   = ((st_q == MD_IDLE) && start_i) || (st_q == MD_BUSY);
   assign done_o   = (st_q == MD_DONE);
   assign result_o = res_q;

endmodule

// File: rtl/exe_stage.sv
// MIPS execute stage: ALU, branch target adder, control gating, muldiv.
// Build option: MULDIV_SIGNED_EN enables signed MUL/DIV/REM.
module exe_stage
   import exe_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int REG_AW = 5
) (
   input logic       clk,
   input logic       rst,
   exe_stage_if.slave bus
);

   localparam int SH_W = $clog2(DATA_W);

   logic              md_busy;
   logic              md_done;
   logic [DATA_W-1:0] md_result;
   logic [SH_W-1:0]   shamt;
   logic [DATA_W-1:0] alu;

   muldiv_unit #(.DATA_W(DATA_W)) u_muldiv (
      .clk      (clk),
      .rst      (rst),
      .start_i  (is_muldiv(bus.EXE_cmd)),
      .op_i     (bus.EXE_cmd),
      .a_i      (bus.Val1),
      .b_i      (bus.Val2),
      .busy_o   (md_busy),
      .done_o   (md_done),
      .result_o (md_result)
   );

   assign shamt = bus.Val2[SH_W-1:0];

   always_comb begin
      alu = '0;
      case (bus.EXE_cmd)
         EXE_ADD: alu = bus.Val1 + bus.Val2;
         EXE_SUB: alu = bus.Val1 - bus.Val2;
         EXE_AND: alu = bus.Val1 & bus.Val2;
         EXE_OR:  alu = bus.Val1 | bus.Val2;
         EXE_NOR: alu = ~(bus.Val1 | bus.Val2);
         EXE_XOR: alu = bus.Val1 ^ bus.Val2;
         EXE_SLL: alu = bus.Val1 << shamt;
         EXE_SRA: alu = $signed(bus.Val1) >>> shamt;
         EXE_SRL: alu = bus.Val1 >> shamt;
         EXE_MUL,
         EXE_DIV,
         EXE_REM: alu = md_done ? md_result : '0;
         default: alu = '0;
      endcase
   end

   assign bus.ALU_result   = alu;
   assign bus.Br_addr      = bus.PC + (bus.Val2 << 2);
   assign bus.Br_taken_out = bus.Br_taken;
   assign bus.ST_val       = bus.Reg2;
   assign bus.Dest_out     = bus.Dest;
   // bubbles into EXE/MEM while the muldiv holds the pipe
   assign bus.MEM_R_en_out = bus.MEM_R_en & ~md_busy;
   assign bus.MEM_W_en_out = bus.MEM_W_en & ~md_busy;
   assign bus.WB_en_out    = bus.WB_en & ~md_busy;
   assign bus.muldiv_stall = md_busy;

endmodule

// File: tb/tb_exe_stage.sv
// Directed bench for exe_stage with a per-cycle reference model.
module tb_exe_stage;
   import exe_pkg::*;

   localparam int W = 32;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_vec = 0;
   int   n_err = 0;
   int   md_cyc = 0;

   exe_stage_if #(.DATA_W(W), .REG_AW(5)) bus ();

   exe_stage #(.DATA_W(W), .REG_AW(5)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   function automatic logic [31:0] model(input logic [3:0] cmd,
                                         input logic [31:0] a,
                                         input logic [31:0] b);
      logic signed [31:0] sa, sb;
      sa = a;
      sb = b;
      case (cmd)
         EXE_ADD: return a + b;
         EXE_SUB: return a - b;
         EXE_AND: return a & b;
         EXE_OR:  return a | b;
         EXE_NOR: return ~(a | b);
         EXE_XOR: return a ^ b;
         EXE_SLL: return a << b[4:0];
         EXE_SRA: return sa >>> b[4:0];
         EXE_SRL: return a >> b[4:0];
         EXE_MUL: return a * b;
`ifdef MULDIV_SIGNED_EN
         EXE_DIV: begin
            if (b == 0) return 32'hFFFF_FFFF;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
            return sa / sb;
         end
         EXE_REM: begin
            if (b == 0) return a;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 0;
            return sa % sb;
         end
`else
         EXE_DIV: return (b == 0) ? 32'hFFFF_FFFF : a / b;
         EXE_REM: return (b == 0) ? a : a % b;
`endif
         default: return 0;
      endcase
   endfunction

   // md_cyc: cycles this muldiv instruction has occupied EXE so far
   always @(posedge clk or posedge rst) begin
      if (rst) md_cyc = 0;
      else if (is_muldiv(bus.EXE_cmd)) md_cyc = (md_cyc == W + 1) ? 0 : md_cyc + 1;
      else md_cyc = 0;
   end

   always @(negedge clk) begin
      logic st_e;
      st_e = is_muldiv(bus.EXE_cmd) && (md_cyc <= W);
      chk("c_braddr", bus.Br_addr, bus.PC + bus.Val2 * 4);
      chk("c_brtk", 32'(bus.Br_taken_out), 32'(bus.Br_taken));
      chk("c_stval", bus.ST_val, bus.Reg2);
      chk("c_dest", 32'(bus.Dest_out), 32'(bus.Dest));
      chk("c_stall", 32'(bus.muldiv_stall), 32'(st_e));
      chk("c_wb", 32'(bus.WB_en_out), 32'(bus.WB_en && !st_e));
      chk("c_mr", 32'(bus.MEM_R_en_out), 32'(bus.MEM_R_en && !st_e));
      chk("c_mw", 32'(bus.MEM_W_en_out), 32'(bus.MEM_W_en && !st_e));
      if (!is_muldiv(bus.EXE_cmd) || md_cyc == W + 1)
         chk("c_alu", bus.ALU_result, model(bus.EXE_cmd, bus.Val1, bus.Val2));
   end

   task automatic drive(input logic [3:0] cmd, input logic [31:0] v1,
                        input logic [31:0] v2);
      @(posedge clk);
      #1;
      bus.EXE_cmd = cmd;
      bus.Val1    = v1;
      bus.Val2    = v2;
   endtask

   task automatic alu_vec(input string nm, input logic [3:0] cmd,
                          input logic [31:0] v1, input logic [31:0] v2,
                          input logic [31:0] exp);
      drive(cmd, v1, v2);
      @(negedge clk);
      #1;
      chk(nm, bus.ALU_result, exp);
      chk({nm, "_stall"}, 32'(bus.muldiv_stall), 0);
   endtask

   task automatic md_vec(input string nm, input logic [3:0] cmd,
                         input logic [31:0] v1, input logic [31:0] v2,
                         input logic [31:0] exp);
      int  n;
      bit  fin;
      n   = 0;
      fin = 0;
      drive(cmd, v1, v2);
      for (int i = 0; i < 100 && !fin; i++) begin
         @(negedge clk);
         #1;
         if (bus.muldiv_stall) n++;
         else fin = 1;
      end
      chk({nm, "_cycles"}, n, W + 1);
      chk(nm, bus.ALU_result, exp);
      chk({nm, "_wb"}, 32'(bus.WB_en_out), 32'(bus.WB_en));
   endtask

   initial begin
      bus.PC       = 32'h0000_0040;
      bus.Val1     = 32'd7;
      bus.Val2     = 32'hFFFF_FFFF;
      bus.Reg2     = 32'hCAFE_0001;
      bus.Dest     = 5'd9;
      bus.Br_taken = 1'b0;
      bus.EXE_cmd  = EXE_ADD;
      bus.MEM_R_en = 1'b0;
      bus.MEM_W_en = 1'b1;
      bus.WB_en    = 1'b1;
      #12;
      chk("rst_stall", 32'(bus.muldiv_stall), 0);
      chk("rst_alu", bus.ALU_result, 32'd6);
      chk("rst_wb", 32'(bus.WB_en_out), 1);
      @(negedge clk);
      #1 rst = 1'b0;

      alu_vec("add", EXE_ADD, 32'd7, 32'hFFFF_FFFF, 32'd6);
      alu_vec("sll", EXE_SLL, 32'd1, 32'd31, 32'h8000_0000);
      alu_vec("sra", EXE_SRA, 32'h8000_0000, 32'd4, 32'hF800_0000);
      alu_vec("srl", EXE_SRL, 32'h8000_0000, 32'd31, 32'd1);
      alu_vec("sub", EXE_SUB, 32'd5, 32'd7, 32'hFFFF_FFFE);
      alu_vec("and", EXE_AND, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000);
      alu_vec("or", EXE_OR, 32'hF0F0_0000, 32'h0000_0F0F, 32'hF0F0_0F0F);
      alu_vec("nor", EXE_NOR, 32'h0F0F_0000, 32'h0000_00FF, 32'hF0F0_FF00);
      alu_vec("xor", EXE_XOR, 32'hAAAA_5555, 32'hFFFF_0000, 32'h5555_5555);
      alu_vec("undef", 4'b0001, 32'd3, 32'd4, 32'd0);

      drive(EXE_ADD, 32'd1, 32'hFFFF_FFFE);
      bus.PC       = 32'h100;
      bus.Br_taken = 1'b1;
      bus.Reg2     = 32'h1234_5678;
      bus.Dest     = 5'd31;
      @(negedge clk);
      #1;
      chk("br_addr", bus.Br_addr, 32'hF8);
      chk("br_tk", 32'(bus.Br_taken_out), 1);
      chk("st_val", bus.ST_val, 32'h1234_5678);
      chk("dest", 32'(bus.Dest_out), 31);
      bus.Br_taken = 1'b0;
      bus.MEM_W_en = 1'b0;
      bus.MEM_R_en = 1'b1;

      md_vec("mul", EXE_MUL, 32'd12345, 32'd6789, 32'd83810205);
      md_vec("div", EXE_DIV, 32'd100, 32'd7, 32'd14);
      md_vec("rem", EXE_REM, 32'd100, 32'd7, 32'd2);
      md_vec("div0", EXE_DIV, 32'd5, 32'd0, 32'hFFFF_FFFF);
      md_vec("rem0", EXE_REM, 32'd5, 32'd0, 32'd5);
      md_vec("mulwrap", EXE_MUL, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE);
`ifdef MULDIV_SIGNED_EN
      md_vec("sdiv", EXE_DIV, -32'sd7, 32'd2, -32'sd3);
      md_vec("srem", EXE_REM, -32'sd7, 32'd2, -32'sd1);
      md_vec("smul", EXE_MUL, -32'sd3, 32'd5, -32'sd15);
      md_vec("ovfdiv", EXE_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
      md_vec("ovfrem", EXE_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
      md_vec("sdiv0", EXE_DIV, -32'sd7, 32'd0, 32'hFFFF_FFFF);
      md_vec("srem0", EXE_REM, -32'sd7, 32'd0, -32'sd7);
`else
      md_vec("udiv", EXE_DIV, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC);
      md_vec("urem", EXE_REM, 32'hFFFF_FFF9, 32'd2, 32'd1);
      md_vec("udivbig", EXE_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
      md_vec("urembig", EXE_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
`endif

      drive(EXE_MUL, 32'h1234, 32'h5678);
      repeat (11) @(negedge clk);
      #1;
      chk("busy_pre_rst", 32'(bus.muldiv_stall), 1);
      rst = 1'b1;
      bus.EXE_cmd = EXE_ADD;
      #1;
      chk("rst_mid_stall", 32'(bus.muldiv_stall), 0);
      chk("rst_mid_alu", bus.ALU_result, 32'h68AC);
      @(negedge clk);
      #1 rst = 1'b0;
      md_vec("mul_after_rst", EXE_MUL, 32'd3, 32'd4, 32'd12);

      alu_vec("add_tail", EXE_ADD, 32'hFFFF_FFFF, 32'd1, 32'd0);
      repeat (2) @(posedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/exe_stage.md
Name: exe_stage

Overview:
- Execute stage of the 5-stage MIPS pipeline.
- Consumes the registered outputs of the ID/EXE pipeline register and computes the ALU result, the branch target, and the store value.
- Passes control bits on to the EXE/MEM register.
- Contains an iterative radix-2 multiply/divide unit. While that unit is busy, the stage raises a stall that freezes IF, IF/ID and ID/EXE.

Parameters:
- DATA_W, 32, datapath width. Operands, results, PC.
- REG_AW, 5, destination register index width.

Ports:
- clk  in  1  pipeline clock.
- rst  in  1  reset, asynchronous, active-high.
- PC  in  DATA_W  PC+4 of the instruction in EXE.
- Val1  in  DATA_W  ALU operand A.
- Val2  in  DATA_W  ALU operand B, or sign-extended immediate.
- Reg2  in  DATA_W  rt value, used as the store data.
- Dest  in  REG_AW  writeback register.
- Br_taken  in  1  branch decided in ID.
- EXE_cmd  in  4  operation code.
- MEM_R_en, MEM_W_en, WB_en  in  1 each  control bits.
- ALU_result  out  DATA_W  result or memory address.
- Br_addr  out  DATA_W  PC + (Val2 << 2).
- Br_taken_out  out  1  Br_taken, passed through.
- ST_val  out  DATA_W  Reg2, passed through.
- Dest_out  out  REG_AW  Dest, passed through.
- MEM_R_en_out, MEM_W_en_out, WB_en_out  out  1 each  gated control bits.
- muldiv_stall  out  1  high while a MUL or DIV is not yet complete.

Behaviour:
- Clock is clk. Reset is asynchronous and active-high on rst.
- EXE_cmd encoding:
  - 0000 ADD, 0010 SUB, 0100 AND, 0101 OR, 0110 NOR, 0111 XOR.
  - 1000 SLL, 1001 SRA, 1010 SRL. Shift amount is Val2[4:0], shifting Val1.
  - 1100 MUL: low DATA_W bits of the product.
  - 1101 DIV: quotient.
  - 1110 REM: remainder.
  - Any other code gives ALU_result = 0.
- Non-muldiv ops are purely combinational with zero latency. Add and subtract wrap modulo 2^DATA_W.
- Br_addr is always computed, wrapping modulo 2^DATA_W.
- Br_taken_out, ST_val and Dest_out are always passed through unchanged.
- Muldiv FSM states: IDLE, BUSY, DONE.
  - IDLE with a muldiv EXE_cmd: capture Val1/Val2, load count = DATA_W-1, go to BUSY. muldiv_stall=1 in this same cycle (combinational from EXE_cmd).
  - BUSY: one shift-add or restoring-subtract step per cycle. muldiv_stall=1. When count==0, go to DONE.
  - DONE: ALU_result = registered result, muldiv_stall=0, go to IDLE next cycle.
  - Total occupancy is DATA_W+2 cycles. Stall is high for DATA_W+1 cycles.
- Inputs are held stable by the freeze while the stall is high. The FSM ignores input changes after capture.
- While muldiv_stall=1, MEM_R_en_out, MEM_W_en_out and WB_en_out are forced 0, so EXE/MEM receives bubbles. In DONE they equal the inputs.
- Divide by zero: quotient = all ones, remainder = dividend. No trap.
- A non-muldiv EXE_cmd in IDLE leaves the FSM in IDLE.
- Back-to-back muldiv instructions: DONE → IDLE → the next capture happens in the following cycle. No overlap.
- Reset values, and reset mid-operation (any state):
  - FSM → IDLE, counter = 0, result register = 0.
  - muldiv_stall = 0 unless the current EXE_cmd is muldiv.
  - The other outputs stay combinational from their inputs.
- Reset mid-BUSY discards the partial result.

Optional Feature:
- MULDIV_SIGNED_EN defined: MUL/DIV/REM treat operands as two's complement.
  - Operands are converted to magnitude on capture and the sign is corrected in DONE.
  - Remainder takes the sign of the dividend.
  - Most-negative ÷ −1 gives quotient = most-negative, remainder = 0.
  - Divide by zero is unchanged.
- Undefined: all muldiv operations are unsigned.

Decomposition:
- Package exe_pkg holds:
  - EXE_cmd localparams: EXE_ADD … EXE_REM.
  - The muldiv state encoding: MD_IDLE, MD_BUSY, MD_DONE.
  - A helper is_muldiv function.
- Sub-module muldiv_unit holds the FSM, counter, operand, accumulator and result registers, and the stall.
  - Its interface: start, op, a, b, busy, done, result.
- exe_stage holds the ALU mux, branch adder, and control gating.

Test Plan:
- ADD Val1=7, Val2=0xFFFFFFFF → ALU_result=6. SLL Val1=1, Val2=31 → 0x80000000. SRA 0x80000000 by 4 → 0xF8000000. Stall stays 0.
- PC=0x100, Val2=0xFFFFFFFE, Br_taken=1 → Br_addr=0xF8, Br_taken_out=1.
- MUL 12345×6789, WB_en=1 → stall high exactly 33 cycles with WB_en_out=0; DONE cycle ALU_result=83810205, WB_en_out=1.
- DIV 100/7 → 14; REM → 2. DIV 5/0 → 0xFFFFFFFF; REM 5/0 → 5.
- Assert rst in the 10th BUSY cycle → stall drops immediately and FSM is IDLE. After release, a fresh MUL 3×4 → 12.
- With MULDIV_SIGNED_EN: DIV −7/2 → −3, REM → −1. MUL −3×5 → −15. 0x80000000 / −1 → 0x80000000, remainder 0.
